// File: rtl/core_pkg.sv
// core_pkg: shared opcode constants, next-pc select encoding and fetch FSM states
package core_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_LUI    = 7'h37;
  typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_JAL, NPC_JALR} npc_sel_e;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: one-entry instruction/pc holding register presented to decode
module fetch_out_buf
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic            consume,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);
  // clear beats load beats consume; data is only replaced on load so it stays stable while held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= XLEN'(NOP_INSTR);
      pc    <= RESET_PC;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, single-outstanding imem fetch FSM and redirect handling
module fetch_unit
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [1:0]      nextpcsel_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcodes_o,
  input  logic            instr_ready_i,
  output logic            misalign_o
);
  fetch_state_e state_q, state_d;
  npc_sel_e sel;
  logic [XLEN-1:0] pc_q, pc_d, eff, tgt;
  logic taken, load, discard_q, discard_d;
  assign sel = npc_sel_e'(nextpcsel_i);
  assign taken = redirect_valid_i & (sel == NPC_JAL | sel == NPC_JALR | (sel == NPC_BR & branch_taken_i));
  assign eff = sel == NPC_JALR ? {target_i[XLEN-1:1], 1'b0} : target_i;
  assign tgt = {eff[XLEN-1:2], 2'b00};
  assign load = state_q == S_WAIT & imem_rvalid_i & ~discard_q & ~taken;
  assign imem_req_o = state_q == S_REQ & ~rst_i;
  assign imem_addr_o = pc_q;
  assign opcodes_o = instr_o[6:0];

  fetch_out_buf #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_buf (
    .clk(clk_i), .rst(rst_i), .load(load), .clear(taken),
    .consume(instr_ready_i), .instr_in(imem_rdata_i), .pc_in(pc_q),
    .valid(instr_valid_o), .instr(instr_o), .pc(pc_o)
  );

  // next state / pc: a taken redirect wins; a response still owed to memory is marked for discard
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    discard_d = discard_q;
    if (taken) begin
      pc_d = tgt;
      discard_d = (state_q == S_WAIT & ~imem_rvalid_i) | (state_q == S_REQ & imem_gnt_i);
      state_d = discard_d ? S_WAIT : S_REQ;
    end else if (state_q == S_REQ) begin
      state_d = imem_gnt_i ? S_WAIT : S_REQ;
    end else if (state_q == S_WAIT & imem_rvalid_i) begin
      discard_d = 1'b0;
      pc_d = discard_q ? pc_q : pc_q + XLEN'(4);
      state_d = discard_q | instr_ready_i ? S_REQ : S_HOLD;
    end else if (state_q == S_HOLD & instr_ready_i) begin
      state_d = S_REQ;
    end
  end

  // state, pc, discard flag and the registered misalignment pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      discard_q <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      discard_q <= discard_d;
      misalign_o <= taken & eff[1];
    end
  end
endmodule
